// File: rtl/m_intr_ctrl_if.sv
// IO port and interrupt request bundle between m_intr_ctrl (slave) and the CPU side (master).
interface m_intr_ctrl_if;
  logic        io_we;
  logic        io_re;
  logic [2:0]  io_adr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  // int_req rises with int_cause valid and both hold until int_ack is sampled high
  // (or the request is withdrawn); int_ack while int_req is low is ignored.
  logic        int_req;
  logic        int_ack;
  logic [3:0]  int_cause;
  logic [1:0]  int_priv;

  modport slave (
    input  io_we, io_re, io_adr, io_wdata, int_ack,
    output io_rdata, int_req, int_cause, int_priv
  );

  modport master (
    output io_we, io_re, io_adr, io_wdata, int_ack,
    input  io_rdata, int_req, int_cause, int_priv
  );
endinterface

// File: rtl/m_intr_ctrl.sv
// Machine-mode interrupt source: mtime/mtimecmp timer, msip, synchronized external line,
// and a prioritized req/ack interrupt request towards the pipeline.
module m_intr_ctrl #(
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  m_intr_ctrl_if.slave  bus,
  input  logic          ext_int_in,
  input  logic          csr_meie,
  input  logic          csr_mtie,
  input  logic          csr_msie,
  input  logic          csr_mstatus_mie,
  output logic          dbg_state_o
);
  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTERM     = PW'(PRESCALE - 1);
  localparam logic [3:0]    CAUSE_MEI = 4'd11;
  localparam logic [3:0]    CAUSE_MSI = 4'd3;
  localparam logic [3:0]    CAUSE_MTI = 4'd7;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;
  logic                   msip_q, msip_d;
  logic                   mtip_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [31:0]            shadow_q, shadow_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             holdoff_q, holdoff_d;
  logic [3:0]             cause_q, cause_d;
  logic                   tick, meip;
  logic                   e_mei, e_msi, e_mti, cause_en;

  assign meip  = sync_q[SYNC_STAGES-1];
  assign e_mei = meip & csr_meie;
  assign e_msi = msip_q & csr_msie;
  assign e_mti = mtip_q & csr_mtie;

  // Register file: timer, msip and the registered read path
  always_comb begin
    tick       = (presc_q == PTERM);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    shadow_d   = shadow_q;
    rdata_d    = '0;
    if (bus.io_we) begin
      case (bus.io_adr)
        3'd0:    mtime_d = {mtime_q[63:32], bus.io_wdata};
        3'd1:    mtime_d = {bus.io_wdata, mtime_q[31:0]};
        3'd2:    mtimecmp_d = {mtimecmp_q[63:32], bus.io_wdata};
        3'd3:    mtimecmp_d = {bus.io_wdata, mtimecmp_q[31:0]};
        3'd4:    msip_d = bus.io_wdata[0];
        default: ;
      endcase
    end
    // Reads see pre-write state; a lo read snapshots hi so a later hi read is coherent
    if (bus.io_re) begin
      case (bus.io_adr)
        3'd0: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        3'd1:    rdata_d = shadow_q;
        3'd2:    rdata_d = mtimecmp_q[31:0];
        3'd3:    rdata_d = mtimecmp_q[63:32];
        3'd4:    rdata_d = {31'd0, msip_q};
        3'd5:    rdata_d = {20'd0, meip, 3'd0, mtip_q, 3'd0, msip_q, 3'd0};
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    if (cause_q == CAUSE_MEI)      cause_en = e_mei;
    else if (cause_q == CAUSE_MSI) cause_en = e_msi;
    else                           cause_en = e_mti;
  end

  // Request FSM; holdoff keeps IDLE from re-requesting while the CSR clears MIE after a take
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    holdoff_d = holdoff_q;
    if (state_q == S_IDLE) begin
      if (holdoff_q != 2'd0) begin
        holdoff_d = holdoff_q - 2'd1;
      end else if (csr_mstatus_mie && (e_mei || e_msi || e_mti)) begin
        state_d = S_REQ;
        if (e_mei)      cause_d = CAUSE_MEI;
        else if (e_msi) cause_d = CAUSE_MSI;
        else            cause_d = CAUSE_MTI;
      end
    end else begin
      if (bus.int_ack) begin
        state_d   = S_IDLE;
        holdoff_d = 2'd2;
      end else if (!csr_mstatus_mie || !cause_en) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      sync_q     <= '0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      holdoff_q  <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_int_in};
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      holdoff_q  <= holdoff_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.io_rdata  = rdata_q;
  assign bus.int_req   = (state_q == S_REQ);
  assign bus.int_cause = cause_q;
  assign bus.int_priv  = 2'b11;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_m_intr_ctrl.sv
// Self-checking bench for m_intr_ctrl: directed scenarios plus randomized priority checks
// against a behavioural model of the interrupt rules.
module tb_m_intr_ctrl;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_int_in, csr_meie, csr_mtie, csr_msie, csr_mstatus_mie;
  logic dbg_state;

  m_intr_ctrl_if bus();

  m_intr_ctrl #(.PRESCALE(1), .SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ext_int_in      (ext_int_in),
    .csr_meie        (csr_meie),
    .csr_mtie        (csr_mtie),
    .csr_msie        (csr_msie),
    .csr_mstatus_mie (csr_mstatus_mie),
    .dbg_state_o     (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  last_cause;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [2:0] a, input logic [31:0] d, output int edge_idx);
    bus.io_we = 1'b1; bus.io_adr = a; bus.io_wdata = d;
    step();
    edge_idx = cyc;
    bus.io_we = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] a, output logic [31:0] d, output int edge_idx);
    bus.io_re = 1'b1; bus.io_adr = a;
    step();
    d = bus.io_rdata;
    edge_idx = cyc;
    bus.io_re = 1'b0;
  endtask

  // model: highest-priority enabled source, MEI > MSI > MTI
  function automatic logic [3:0] model_cause(input logic mei, input logic msi, input logic mti);
    if (mei) return 4'd11;
    if (msi) return 4'd3;
    if (mti) return 4'd7;
    return 4'd0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd, exp_v, r1;
    logic        b;
    int e, bad;
    #2;
    n_checks++;
    if (bus.int_req !== 1'b0 || bus.int_cause !== 4'd0 || bus.io_rdata !== 32'd0)
      $display("FAIL reset_outputs: got req=%0b cause=%0d rdata=%0h expected 0/0/0", bus.int_req, bus.int_cause, bus.io_rdata);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd0);         exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] adrs [4] = '{3'd2, 3'd3, 3'd5, 3'd4};
      io_read(adrs[i], rd, e);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) $display("FAIL reset_read_adr%0d: got %0h expected %0h", adrs[i], rd, exp_v);
      else n_pass++;
    end
    step();
    n_checks++;
    if (bus.io_rdata !== 32'd0) $display("FAIL rdata_idle_zero: got %0h expected 0", bus.io_rdata);
    else n_pass++;
    n_checks++;
    if (bus.int_priv !== 2'b11) $display("FAIL int_priv: got %0b expected 11", bus.int_priv);
    else n_pass++;

    csr_meie = 1; csr_mtie = 1; csr_msie = 1; csr_mstatus_mie = 1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.int_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL idle_no_request: got %0d cycles with req expected 0", bad);
    else n_pass++;
    csr_meie = 0; csr_mtie = 0; csr_msie = 0; csr_mstatus_mie = 0;

    // register readback, unmapped address, read-during-write
    r1 = $urandom;
    b  = 1'($urandom_range(0, 1));
    io_write(3'd2, r1, e);
    io_write(3'd4, {$urandom, 1'b0} | 32'(b), e);
    io_write(3'd6, $urandom, e);
    exp_q.push_back(r1); exp_q.push_back({31'd0, b}); exp_q.push_back(32'd0);
    for (int i = 0; i < 3; i++) begin
      logic [2:0] adrs [3] = '{3'd2, 3'd4, 3'd6};
      io_read(adrs[i], rd, e);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) $display("FAIL readback_adr%0d: got %0h expected %0h", adrs[i], rd, exp_v);
      else n_pass++;
    end
    bus.io_we = 1; bus.io_re = 1; bus.io_adr = 3'd2; bus.io_wdata = ~r1;
    step();
    bus.io_we = 0; bus.io_re = 0;
    n_checks++;
    if (bus.io_rdata !== r1) $display("FAIL read_during_write: got %0h expected %0h", bus.io_rdata, r1);
    else n_pass++;
    io_read(3'd2, rd, e);
    n_checks++;
    if (rd !== ~r1) $display("FAIL write_after_rw: got %0h expected %0h", rd, ~r1);
    else n_pass++;
    io_write(3'd2, 32'hFFFF_FFFF, e);
    io_write(3'd4, 32'd0, e);
  endtask

  task automatic test_mtime();
    logic [31:0] lo_r, hi_r, hi_v, lo_v;
    logic [63:0] base, exp64;
    int w, w2, r0, r1;
    // wrap into the upper half, read lo then hi
    io_write(3'd1, 32'd0, w);
    io_write(3'd0, 32'hFFFF_FFFE, w2);
    repeat (3) step();
    io_read(3'd0, lo_r, r0);
    io_read(3'd1, hi_r, r1);
    n_checks++;
    if (lo_r !== 32'd1 || hi_r !== 32'd1) $display("FAIL mtime_wrap: got hi=%0h lo=%0h expected 1/1", hi_r, lo_r);
    else n_pass++;
    // shadow stays at the value captured by the lo read even after the carry
    io_write(3'd1, 32'd0, w);
    io_write(3'd0, 32'hFFFF_FFFE, w2);
    io_read(3'd0, lo_r, r0);
    repeat (3) step();
    io_read(3'd1, hi_r, r1);
    n_checks++;
    if (lo_r !== 32'hFFFF_FFFE || hi_r !== 32'd0) $display("FAIL shadow_coherent: got hi=%0h lo=%0h expected 0/fffffffe", hi_r, lo_r);
    else n_pass++;
    // randomized values near the 32-bit carry
    for (int i = 0; i < 5; i++) begin
      hi_v = $urandom;
      lo_v = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
      io_write(3'd1, hi_v, w);
      io_write(3'd0, lo_v, w2);
      base = {hi_v, lo_v};
      repeat ($urandom_range(0, 4)) step();
      io_read(3'd0, lo_r, r0);
      exp64 = base + 64'(r0 - 1 - w2);
      repeat ($urandom_range(1, 5)) step();
      io_read(3'd1, hi_r, r1);
      n_checks++;
      if ({hi_r, lo_r} !== exp64) $display("FAIL mtime_rand%0d: got %0h expected %0h", i, {hi_r, lo_r}, exp64);
      else n_pass++;
    end
  endtask

  task automatic test_timer();
    int w, w0, reach, rise, k, bad;
    csr_mstatus_mie = 1; csr_mtie = 0;
    io_write(3'd1, 32'd0, w);
    io_write(3'd0, 32'd0, w0);
    io_write(3'd3, 32'd0, w);
    io_write(3'd2, 32'd20, w);
    csr_mtie = 1;
    reach = w0 + 20;
    rise = -1;
    for (int i = 0; i < 40 && rise < 0; i++) begin
      step();
      if (bus.int_req === 1'b1) rise = cyc;
    end
    n_checks++;
    if (rise < reach + 1 || rise > reach + 2)
      $display("FAIL timer_latency: got %0d cycles after mtime==20 expected 1..2", rise - reach);
    else n_pass++;
    n_checks++;
    if (bus.int_cause !== 4'd7) $display("FAIL timer_cause: got %0d expected 7", bus.int_cause);
    else n_pass++;
    bad = 0;
    repeat ($urandom_range(3, 8)) begin
      step();
      if (bus.int_req !== 1'b1 || bus.int_cause !== 4'd7) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL timer_hold: got %0d unstable cycles expected 0", bad);
    else n_pass++;
    bus.int_ack = 1;
    step();
    k = cyc;
    bus.int_ack = 0;
    n_checks++;
    if (bus.int_req !== 1'b0) $display("FAIL timer_ack_drop: got %0b expected 0", bus.int_req);
    else n_pass++;
    bad = 0;
    repeat (2) begin
      step();
      if (bus.int_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL timer_holdoff: got %0d early requests expected 0", bad);
    else n_pass++;
    step();
    n_checks++;
    if (bus.int_req !== 1'b1 || cyc !== k + 3) $display("FAIL timer_rerequest: got req=%0b at +%0d expected 1 at +3", bus.int_req, cyc - k);
    else n_pass++;
    csr_mtie = 0;
    step();
    n_checks++;
    if (bus.int_req !== 1'b0) $display("FAIL timer_withdraw: got %0b expected 0", bus.int_req);
    else n_pass++;
    io_write(3'd3, 32'hFFFF_FFFF, w);
    io_write(3'd2, 32'hFFFF_FFFF, w);
    csr_mstatus_mie = 0;
    repeat (3) step();
  endtask

  task automatic test_priority();
    int w;
    csr_mstatus_mie = 0; csr_meie = 1; csr_msie = 1; csr_mtie = 1;
    ext_int_in = 1;
    io_write(3'd4, 32'd1, w);
    repeat (SYNC + 1) step();
    csr_mstatus_mie = 1;
    step();
    n_checks++;
    if (bus.int_req !== 1'b1 || bus.int_cause !== 4'd11) $display("FAIL prio_mei: got req=%0b cause=%0d expected 1/11", bus.int_req, bus.int_cause);
    else n_pass++;
    csr_meie = 0;
    step();
    n_checks++;
    if (bus.int_req !== 1'b0) $display("FAIL prio_withdraw: got %0b expected 0", bus.int_req);
    else n_pass++;
    step();
    n_checks++;
    if (bus.int_req !== 1'b1 || bus.int_cause !== 4'd3) $display("FAIL prio_msi: got req=%0b cause=%0d expected 1/3", bus.int_req, bus.int_cause);
    else n_pass++;
    csr_meie = 1;
    repeat (2) step();
    n_checks++;
    if (bus.int_req !== 1'b1 || bus.int_cause !== 4'd3) $display("FAIL prio_no_preempt: got req=%0b cause=%0d expected 1/3", bus.int_req, bus.int_cause);
    else n_pass++;
    bus.int_ack = 1;
    step();
    bus.int_ack = 0; csr_mstatus_mie = 0; ext_int_in = 0;
    io_write(3'd4, 32'd0, w);
    repeat (4) step();
  endtask

  task automatic test_ack_vs_withdraw();
    int w, k, bad;
    csr_meie = 0; csr_mtie = 0; csr_msie = 1; csr_mstatus_mie = 1;
    io_write(3'd4, 32'd1, w);
    for (int i = 0; i < 5 && bus.int_req !== 1'b1; i++) step();
    n_checks++;
    if (bus.int_req !== 1'b1 || bus.int_cause !== 4'd3) $display("FAIL aw_request: got req=%0b cause=%0d expected 1/3", bus.int_req, bus.int_cause);
    else n_pass++;
    csr_mstatus_mie = 0; bus.int_ack = 1;
    step();
    k = cyc;
    bus.int_ack = 0; csr_mstatus_mie = 1;
    bad = 0;
    if (bus.int_req !== 1'b0) bad++;
    repeat (2) begin
      step();
      if (bus.int_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL aw_holdoff: got %0d early requests expected 0", bad);
    else n_pass++;
    step();
    n_checks++;
    if (bus.int_req !== 1'b1 || cyc !== k + 3) $display("FAIL aw_rerequest: got req=%0b at +%0d expected 1 at +3", bus.int_req, cyc - k);
    else n_pass++;
    bus.int_ack = 1;
    step();
    bus.int_ack = 0; csr_mstatus_mie = 0;
    io_write(3'd4, 32'd0, w);
    repeat (4) step();
    last_cause = 4'd3;
  endtask

  task automatic test_random_prio();
    int w;
    logic s_ext, s_sw, s_tm, mei, msi, mti, exp_req;
    logic [3:0] exp_cause;
    for (int i = 0; i < 12; i++) begin
      csr_mstatus_mie = 0;
      s_ext = 1'($urandom_range(0, 1));
      s_sw  = 1'($urandom_range(0, 1));
      s_tm  = 1'($urandom_range(0, 1));
      csr_meie = 1'($urandom_range(0, 1));
      csr_msie = 1'($urandom_range(0, 1));
      csr_mtie = 1'($urandom_range(0, 1));
      ext_int_in = s_ext;
      io_write(3'd4, 32'(s_sw), w);
      io_write(3'd2, s_tm ? 32'd0 : 32'hFFFF_FFFF, w);
      io_write(3'd3, s_tm ? 32'd0 : 32'hFFFF_FFFF, w);
      repeat (SYNC + 2) step();
      csr_mstatus_mie = 1;
      step();
      mei = s_ext & csr_meie; msi = s_sw & csr_msie; mti = s_tm & csr_mtie;
      exp_req   = mei | msi | mti;
      exp_cause = exp_req ? model_cause(mei, msi, mti) : last_cause;
      n_checks++;
      if (bus.int_req !== exp_req || bus.int_cause !== exp_cause)
        $display("FAIL rand_prio%0d: got req=%0b cause=%0d expected %0b/%0d", i, bus.int_req, bus.int_cause, exp_req, exp_cause);
      else n_pass++;
      if (exp_req) begin
        last_cause = exp_cause;
        bus.int_ack = 1;
        step();
        bus.int_ack = 0;
      end
      csr_mstatus_mie = 0;
      repeat (3) step();
    end
    ext_int_in = 0; csr_meie = 0; csr_msie = 0; csr_mtie = 0;
    io_write(3'd4, 32'd0, w);
    io_write(3'd2, 32'hFFFF_FFFF, w);
    io_write(3'd3, 32'hFFFF_FFFF, w);
    repeat (4) step();
  endtask

  task automatic test_ext_reset();
    int bad, e;
    logic [31:0] rd;
    csr_meie = 1; csr_mstatus_mie = 1;
    step();
    ext_int_in = 1;
    bad = 0;
    repeat (SYNC) begin
      step();
      if (bus.int_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL ext_too_early: got %0d early requests expected 0", bad);
    else n_pass++;
    step();
    n_checks++;
    if (bus.int_req !== 1'b1 || bus.int_cause !== 4'd11) $display("FAIL ext_request: got req=%0b cause=%0d expected 1/11", bus.int_req, bus.int_cause);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.int_req !== 1'b0 || bus.int_cause !== 4'd0) $display("FAIL async_reset: got req=%0b cause=%0d expected 0/0", bus.int_req, bus.int_cause);
    else n_pass++;
    ext_int_in = 0; csr_meie = 0; csr_mstatus_mie = 0;
    repeat (2) step();
    rst = 1'b0;
    io_read(3'd3, rd, e);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF || bus.int_req !== 1'b0) $display("FAIL post_reset: got cmp_hi=%0h req=%0b expected ffffffff/0", rd, bus.int_req);
    else n_pass++;
  endtask

  initial begin
    bus.io_we = 0; bus.io_re = 0; bus.io_adr = '0; bus.io_wdata = '0; bus.int_ack = 0;
    ext_int_in = 0; csr_meie = 0; csr_mtie = 0; csr_msie = 0; csr_mstatus_mie = 0;
    last_cause = 4'd0;
    test_reset();
    test_mtime();
    test_timer();
    test_priority();
    test_ack_vs_withdraw();
    test_random_prio();
    test_ext_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/m_intr_ctrl.md
Name: m_intr_ctrl

Overview:
- Machine-mode interrupt source for the M-mode-only RV32I core. It sits on the CPU side of the CSR block.
- Holds the machine timer (mtime/mtimecmp), the software-interrupt bit (msip) and a synchronized external interrupt line, all on a small word-addressed IO port.
- Combines these pending sources with the CSR enables (MEIE/MTIE/MSIE, mstatus.MIE) and presents one prioritized interrupt request, with its cause, to the pipeline under a req/ack handshake.

Parameters:
PRESCALE, 1, clocks per mtime increment (>=1)
SYNC_STAGES, 2, flip-flop stages on ext_int_in (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
io_we  in  1  IO write strobe
io_re  in  1  IO read strobe
io_adr  in  3  word index
io_wdata  in  32  write data
io_rdata  out  32  read data, one cycle after io_re
ext_int_in  in  1  asynchronous external interrupt level
csr_meie  in  1  external interrupt enable
csr_mtie  in  1  timer interrupt enable
csr_msie  in  1  software interrupt enable
csr_mstatus_mie  in  1  global machine interrupt enable
int_ack  in  1  pipeline has taken the interrupt (not stalled)
int_req  out  1  interrupt request (g_interrupt source)
int_cause  out  4  mcause code of the request
int_priv  out  2  privilege of the request, constant 2'b11

Behaviour:
- Reset: everything async on rst high.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, sync chain=0, hi shadow=0, holdoff=0.
  - Outputs: int_req=0, int_cause=0, io_rdata=0.
- Address map (io_adr):
  - 0 mtime[31:0]; 1 mtime[63:32]; 2 mtimecmp[31:0]; 3 mtimecmp[63:32].
  - 4 msip (bit0 R/W, other bits read 0).
  - 5 pending, read-only: {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0}.
  - 6 and 7: read 0, writes ignored.
- Prescaler:
  - Counts 0..PRESCALE-1; on the terminal count it wraps to 0 and mtime increments by 1.
  - mtime is 64-bit and wraps from all-ones to 0.
- Writes take effect at the clock edge.
  - A write to mtime lo or hi replaces that half and suppresses the increment in that cycle; the other half is unchanged.
  - The prescaler keeps running during mtime writes.
- Coherent read:
  - Reading adr 0 returns mtime[31:0] and copies mtime[63:32] into the hi shadow in the same cycle.
  - Reading adr 1 returns the shadow, not live mtime.
- io_rdata is registered: valid the cycle after io_re, 0 in cycles with no read.
- Simultaneous io_we and io_re: the read returns the pre-write value.
- Pending sources (raw):
  - mtip: registered (mtime >= mtimecmp), unsigned 64-bit compare, 1-cycle lag after mtime or mtimecmp changes.
  - meip: last stage of the SYNC_STAGES synchronizer; level-sensitive, not latched.
  - msip: register bit.
- Enabled set: E = {meip&csr_meie, msip&csr_msie, mtip&csr_mtie}.
  - Fixed priority MEI > MSI > MTI.
  - Cause codes: MEI 11, MSI 3, MTI 7.
- Request state machine (registered). States:
  - IDLE: if csr_mstatus_mie & |E & holdoff==0, go to REQ. Set int_req=1 and latch int_cause from the highest-priority bit.
  - REQ: int_req and int_cause held stable.
    - int_ack=1: go to IDLE with int_req=0 and holdoff=2.
    - Else, if csr_mstatus_mie=0 or the latched cause's enabled bit drops: withdraw, go to IDLE with int_req=0, holdoff unchanged.
    - A higher-priority source arriving while in REQ does not change int_cause.
    - int_ack and withdraw in the same cycle: ack wins.
  - holdoff: decrements to 0 each cycle in IDLE. It blocks re-request while the CSR clears MIE after a take.
- int_ack while int_req=0 is ignored.
- int_cause keeps its last value when int_req=0.
- Reset asserted mid-request: int_req drops immediately (async); holdoff is cleared.

Test Plan:
- Reset, then read adr 2 and 3: 32'hFFFF_FFFF both; read adr 5: 0; int_req stays 0 for 100 cycles with all enables set.
- PRESCALE=1: write mtime hi=0, lo=32'hFFFF_FFFE; three cycles later read lo then hi: lo=1, hi=1; shadow hi is coherent across a further increment.
- mtimecmp=20, csr_mtie=1, mstatus_mie=1, mtime from 0: int_req=1 with cause 7 within 2 cycles of mtime reaching 20; hold until int_ack, then int_req=0 next cycle; no re-request for 2 cycles.
- Set msip=1 and ext_int_in=1 together, all enables on: int_cause=11. Drop csr_meie before ack: int_req withdraws; it then re-requests with cause 3.
- Request pending, drop csr_mstatus_mie and pulse int_ack in the same cycle: ack wins and holdoff=2 is loaded.
- ext_int_in pulse: int_req rises no earlier than SYNC_STAGES+1 cycles later; assert rst while int_req=1: int_req=0 without waiting for a clock edge.
